// File: rtl/sonar_scheduler.sv
// Round-robin scheduler for three HC-SR04 ultrasonic sensors: triggers each in turn,
// times its echo in microsecond ticks and publishes distance in cm, or 4095 on timeout.
module sonar_scheduler #(
    parameter int CLK_HZ      = 50000000,
    parameter int TRIG_US     = 10,
    parameter int WAIT_MAX_US = 1000,
    parameter int ECHO_MAX_US = 30000,
    parameter int GAP_US      = 60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [2:0]  echo,
    output logic [2:0]  trig,
    output logic [11:0] distance1,
    output logic [11:0] distance2,
    output logic [11:0] distance3,
    output logic [2:0]  valid,
    output logic [2:0]  timeout,
    output logic [1:0]  sel
);

    localparam int DIV  = CLK_HZ / 1000000;
    localparam int PW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int T1   = (TRIG_US > WAIT_MAX_US) ? TRIG_US : WAIT_MAX_US;
    localparam int T2   = (ECHO_MAX_US > GAP_US) ? ECHO_MAX_US : GAP_US;
    localparam int TMAX = (T1 > T2) ? T1 : T2;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [CW-1:0] TRIG_LAST  = CW'(TRIG_US - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_MAX_US - 1);
    localparam logic [CW-1:0] ECHO_LAST  = CW'(ECHO_MAX_US - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_US - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [2:0]        echo_meta_q, echo_meta_d;
    logic [2:0]        echo_sync_q, echo_sync_d;
    logic [CW-1:0]     us_cnt_q, us_cnt_d;
    logic [5:0]        sub_q, sub_d;
    logic [11:0]       cm_q, cm_d;
    logic [1:0]        sel_q, sel_d;
    logic [2:0]        trig_q, trig_d;
    logic [2:0]        valid_q, valid_d;
    logic [2:0]        timeout_q, timeout_d;
    logic [2:0][11:0]  dist_q, dist_d;
    logic              us_tick_s;
    logic              echo_sel_s;
    logic [1:0]        sel_next_s;

    function automatic logic [2:0] sel_onehot(input logic [1:0] s);
        case (s)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign us_tick_s  = (pre_q == PRE_LAST);
    assign echo_sel_s = echo_sync_q[sel_q];
    assign sel_next_s = (sel_q == 2'd2) ? 2'd0 : (sel_q + 2'd1);

    // Next-state logic for the measurement sequencer and its counters.
    always_comb begin
        state_d     = state_q;
        pre_d       = us_tick_s ? {PW{1'b0}} : (pre_q + PW'(1));
        echo_meta_d = echo;
        echo_sync_d = echo_meta_q;
        us_cnt_d    = us_cnt_q;
        sub_d       = sub_q;
        cm_d        = cm_q;
        sel_d       = sel_q;
        trig_d      = trig_q;
        valid_d     = 3'b000;
        timeout_d   = timeout_q;
        dist_d      = dist_q;

        case (state_q)
            IDLE: begin
                trig_d = 3'b000;
                if (enable) begin
                    // Realign the timebase so the trigger pulse is exactly TRIG_US long.
                    state_d  = TRIG;
                    us_cnt_d = {CW{1'b0}};
                    pre_d    = {PW{1'b0}};
                    trig_d   = sel_onehot(sel_q);
                end else begin
                    state_d = IDLE;
                end
            end
            TRIG: begin
                if (us_tick_s) begin
                    if (us_cnt_q == TRIG_LAST) begin
                        trig_d   = 3'b000;
                        state_d  = WAIT_RISE;
                        us_cnt_d = {CW{1'b0}};
                    end else begin
                        us_cnt_d = us_cnt_q + CW'(1);
                    end
                end else begin
                    us_cnt_d = us_cnt_q;
                end
            end
            WAIT_RISE: begin
                if (echo_sel_s) begin
                    state_d  = MEASURE;
                    us_cnt_d = {CW{1'b0}};
                    sub_d    = 6'd0;
                    cm_d     = 12'd0;
                end else if (us_tick_s) begin
                    if (us_cnt_q == WAIT_LAST) begin
                        dist_d[sel_q]    = 12'hFFF;
                        timeout_d[sel_q] = 1'b1;
                        valid_d          = sel_onehot(sel_q);
                        state_d          = GAP;
                        us_cnt_d         = {CW{1'b0}};
                    end else begin
                        us_cnt_d = us_cnt_q + CW'(1);
                    end
                end else begin
                    us_cnt_d = us_cnt_q;
                end
            end
            MEASURE: begin
                if (!echo_sel_s) begin
                    dist_d[sel_q]    = cm_q;
                    timeout_d[sel_q] = 1'b0;
                    valid_d          = sel_onehot(sel_q);
                    state_d          = GAP;
                    us_cnt_d         = {CW{1'b0}};
                end else if (us_tick_s) begin
                    if (us_cnt_q == ECHO_LAST) begin
                        dist_d[sel_q]    = 12'hFFF;
                        timeout_d[sel_q] = 1'b1;
                        valid_d          = sel_onehot(sel_q);
                        state_d          = GAP;
                        us_cnt_d         = {CW{1'b0}};
                    end else begin
                        us_cnt_d = us_cnt_q + CW'(1);
                        // 58 us of round-trip echo per centimetre; 4095 is reserved for timeouts.
                        if (sub_q == 6'd57) begin
                            sub_d = 6'd0;
                            cm_d  = (cm_q == 12'd4094) ? cm_q : (cm_q + 12'd1);
                        end else begin
                            sub_d = sub_q + 6'd1;
                        end
                    end
                end else begin
                    us_cnt_d = us_cnt_q;
                end
            end
            GAP: begin
                trig_d = 3'b000;
                if (us_tick_s) begin
                    if (us_cnt_q == GAP_LAST) begin
                        sel_d    = sel_next_s;
                        us_cnt_d = {CW{1'b0}};
                        if (enable) begin
                            state_d = TRIG;
                            trig_d  = sel_onehot(sel_next_s);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        us_cnt_d = us_cnt_q + CW'(1);
                    end
                end else begin
                    us_cnt_d = us_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                trig_d  = 3'b000;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pre_q       <= {PW{1'b0}};
            echo_meta_q <= 3'b000;
            echo_sync_q <= 3'b000;
            us_cnt_q    <= {CW{1'b0}};
            sub_q       <= 6'd0;
            cm_q        <= 12'd0;
            sel_q       <= 2'd0;
            trig_q      <= 3'b000;
            valid_q     <= 3'b000;
            timeout_q   <= 3'b000;
            dist_q      <= {3{12'd0}};
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            echo_meta_q <= echo_meta_d;
            echo_sync_q <= echo_sync_d;
            us_cnt_q    <= us_cnt_d;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            sel_q       <= sel_d;
            trig_q      <= trig_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            dist_q      <= dist_d;
        end
    end

    assign trig      = trig_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign sel       = sel_q;
    assign distance1 = dist_q[0];
    assign distance2 = dist_q[1];
    assign distance3 = dist_q[2];

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed + randomized bench for sonar_scheduler; expected distances, flags and
// timing come from a microsecond-level model of the sensor protocol.
module tb_sonar_scheduler;

    localparam int CLK_HZ = 2000000;
    localparam int TRIG   = 10;
    localparam int WAITM  = 100;
    localparam int ECHOM  = 3000;
    localparam int GAPU   = 200;
    localparam int CPU    = CLK_HZ / 1000000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [2:0]  echo;
    logic [2:0]  trig;
    logic [11:0] distance1, distance2, distance3;
    logic [2:0]  valid;
    logic [2:0]  timeout;
    logic [1:0]  sel;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_dist [3];
    logic [2:0]  exp_to;
    int          exp_sel;

    sonar_scheduler #(
        .CLK_HZ(CLK_HZ), .TRIG_US(TRIG), .WAIT_MAX_US(WAITM),
        .ECHO_MAX_US(ECHOM), .GAP_US(GAPU)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig),
        .distance1(distance1), .distance2(distance2), .distance3(distance3),
        .valid(valid), .timeout(timeout), .sel(sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_d1"}, 32'(distance1), 32'(exp_dist[0]));
        chk({tag, "_d2"}, 32'(distance2), 32'(exp_dist[1]));
        chk({tag, "_d3"}, 32'(distance3), 32'(exp_dist[2]));
        chk({tag, "_to"}, 32'(timeout), 32'(exp_to));
    endtask

    // One full sensor pass. Echo edges are driven on whole-microsecond boundaries
    // measured from the negedge where the trigger is first seen low.
    task automatic do_pass(input int d_us, input int w_us, input bit no_echo,
                           input bit stuck, input bit drop_en, input bit noise);
        int          s;
        int          n;
        int          t;
        int          g;
        int          exp_t;
        bit          got;
        logic [11:0] e;
        s = exp_sel;
        if (stuck) echo[s] = 1'b1;
        n = 0;
        while (trig === 3'b000 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("trig_start", 32'(trig), 32'(1 << s));
        chk("sel_at_trig", 32'(sel), 32'(s));
        n = 0;
        while (trig !== 3'b000 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("trig_width", 32'(n), 32'(TRIG * CPU));

        // Model: timeout if no echo within WAIT_MAX or echo lasts ECHO_MAX;
        // valid appears 2 sync cycles plus one register after the echo falls.
        if (no_echo) begin
            e = 12'hFFF; exp_t = WAITM * CPU;
        end else if (stuck) begin
            e = 12'hFFF; exp_t = ECHOM * CPU;
        end else if (w_us >= ECHOM) begin
            e = 12'hFFF; exp_t = 2 * CPU * 0 + d_us * CPU + 2 + ECHOM * CPU;
        end else begin
            e = (w_us / 58 > 4094) ? 12'd4094 : 12'(w_us / 58);
            exp_t = d_us * CPU + w_us * CPU + 3;
        end

        t = 0;
        got = 1'b0;
        while (!got && t < CPU * (WAITM + ECHOM) + 500) begin
            if (valid !== 3'b000) begin
                got = 1'b1;
            end else begin
                if (!no_echo && !stuck)
                    echo[s] = (t >= d_us * CPU) && (t < (d_us + w_us) * CPU);
                if (noise)
                    for (int k = 0; k < 3; k++)
                        if (k != s) echo[k] = 1'($urandom_range(0, 1));
                if (drop_en && t == d_us * CPU + w_us) enable = 1'b0;
                @(negedge clk);
                t++;
            end
        end
        chk("valid_seen", 32'(got), 32'd1);
        chk("valid_latency", 32'(t), 32'(exp_t));
        chk("valid_bit", 32'(valid), 32'(1 << s));
        exp_dist[s] = e;
        exp_to[s]   = (e == 12'hFFF);
        chk_outputs("result");
        echo = 3'b000;
        @(negedge clk);
        chk("valid_pulse", 32'(valid), 32'd0);

        g = 1;
        while (sel === 2'(s) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("gap_len", 32'(g >= GAPU * CPU - CPU + 1 && g <= GAPU * CPU), 32'd1);
        exp_sel = (s + 1) % 3;
        chk("sel_next", 32'(sel), 32'(exp_sel));
        if (enable) chk("trig_with_sel", 32'(trig), 32'(1 << exp_sel));
        chk_outputs("hold");
    endtask

    initial begin
        int n;
        int d;
        int w;
        rst = 1'b1;
        enable = 1'b0;
        echo = 3'b000;
        for (int i = 0; i < 3; i++) exp_dist[i] = 12'd0;
        exp_to = 3'b000;
        exp_sel = 0;
        repeat (3) @(negedge clk);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk_outputs("rst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_trig", 32'(trig), 32'd0);
        enable = 1'b1;

        do_pass(50, 1160, 1'b0, 1'b0, 1'b0, 1'b0);   // 20 cm
        do_pass(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);       // sensor 1 silent
        do_pass(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);       // sensor 2 stuck high
        do_pass(5, 57, 1'b0, 1'b0, 1'b0, 1'b0);      // just under 1 cm
        do_pass(7, 116, 1'b0, 1'b0, 1'b0, 1'b0);     // exactly 2 cm
        do_pass(3, 58, 1'b0, 1'b0, 1'b0, 1'b0);      // exactly 1 cm, clears timeout

        for (int i = 0; i < 9; i++) begin
            d = $urandom_range(0, 80);
            w = $urandom_range(1, 700);
            do_pass(d, w, ($urandom_range(0, 5) == 0), 1'b0, 1'b0, 1'b0);
        end

        // Dropping enable mid-measurement still completes the pass and its gap.
        do_pass(10, 300, 1'b0, 1'b0, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (trig !== 3'b000) n++;
        end
        chk("idle_trig_quiet", 32'(n), 32'd0);
        chk("idle_sel", 32'(sel), 32'd1);
        enable = 1'b1;
        @(negedge clk);
        chk("idle_to_trig", 32'(trig), 32'b010);
        do_pass(20, 200, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while sensor 2 is being measured.
        n = 0;
        while (trig === 3'b000 && n < 3000) begin @(negedge clk); n++; end
        n = 0;
        while (trig !== 3'b000 && n < 100) begin @(negedge clk); n++; end
        echo[2] = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) exp_dist[i] = 12'd0;
        exp_to = 3'b000;
        exp_sel = 0;
        chk("mrst_trig", 32'(trig), 32'd0);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_sel", 32'(sel), 32'd0);
        chk_outputs("mrst");
        rst = 1'b0;
        echo = 3'b000;

        do_pass(30, 400, 1'b0, 1'b0, 1'b0, 1'b1);    // noise on sensors 1 and 2

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
